stf_plateau_detect: RTL and testbench

Downstream stage of the 802.11a short-training-sequence (STF) detector. Consumes the sliding-window averaged delay-correlation (I/Q) and averaged power streams produced by the accumulate/average stages. Forms an alpha-max-beta-min correlation magnitude and compares it against a scaled power threshold per sample. Declares packet start once the ratio stays high for a plateau of `PLATEAU_LEN` samples, tolerating short dropouts; the result is handed to the coarse-timing/CFO stage.

---
 rtl/stf_plateau_detect.sv | 116 +++++++++++
 tb/tb_stf_plateau_detect.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/stf_plateau_detect.sv
// stf_plateau_detect: STF packet-start detector (correlation/power ratio plateau with dropout tolerance)
// Ports: clk, rst_n (async active-low); enable (low clears all state), clear (re-arm);
//        avg_valid/avg_corr_i/avg_corr_q/avg_pwr (aligned averaged samples);
//        stf_detect (pulse), stf_detected (level), detect_index (index of completing hit), state_dbg.
module stf_plateau_detect #(
  parameter int DATA_WIDTH  = 32,
  parameter int PLATEAU_LEN = 32,
  parameter int THRESH_NUM  = 6,
  parameter int PWR_MIN     = 64,
  parameter int MISS_TOL    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  avg_valid,
  input  logic [DATA_WIDTH-1:0] avg_corr_i,
  input  logic [DATA_WIDTH-1:0] avg_corr_q,
  input  logic [DATA_WIDTH-1:0] avg_pwr,
  output logic                  stf_detect,
  output logic                  stf_detected,
  output logic [15:0]           detect_index,
  output logic [1:0]            state_dbg
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DETECT, HOLD} state_e;
  // Two's-complement magnitude; the most-negative value saturates instead of wrapping to itself.
  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
    return !x[W-1] ? x : (x[W-2:0] == '0) ? {1'b0, {(W-1){1'b1}}} : -x;
  endfunction
  logic [15:0]  sample_cnt_q, idx1_q, idx2_q, idx3_q, detect_index_q, detect_index_d;
  logic         v1_q, v2_q, v3_q, pok_q, hit3_q;
  logic [W-1:0] abs_i_q, abs_q_q, pwr1_q, mx, mn;
  logic [W:0]   mag;
  logic [W+3:0] lhs_q, rhs_q;
  logic [9:0]   hit_cnt_q, hit_cnt_d, hit_n;
  logic [2:0]   miss_cnt_q, miss_cnt_d;
  logic [3:0]   miss_n;
  state_e       state_q, state_d;
  assign mx     = abs_i_q > abs_q_q ? abs_i_q : abs_q_q;
  assign mn     = abs_i_q > abs_q_q ? abs_q_q : abs_i_q;
  assign mag    = {1'b0, mx} + {3'b0, mn[W-1:2]} + {4'b0, mn[W-1:3]};
  assign hit_n  = hit_cnt_q + 10'd1;
  // One bit wider than the counter so a MISS_TOL of 7 can still be exceeded.
  assign miss_n = {1'b0, miss_cnt_q} + 4'd1;
  always_comb begin
    state_d        = state_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    detect_index_d = detect_index_q;
    case (state_q)
      IDLE: if (v3_q && hit3_q) begin
        state_d    = RUN;
        hit_cnt_d  = 10'd1;
        miss_cnt_d = 3'd0;
      end
      RUN: if (v3_q) begin
        if (hit3_q) begin
          hit_cnt_d  = hit_n;
          miss_cnt_d = 3'd0;
          if (hit_n == 10'(PLATEAU_LEN)) begin
            state_d        = DETECT;
            detect_index_d = idx3_q;
          end
        end else if (miss_n > 4'(MISS_TOL)) begin
          state_d    = IDLE;
          hit_cnt_d  = 10'd0;
          miss_cnt_d = 3'd0;
        end else miss_cnt_d = miss_n[2:0];
      end
      DETECT: state_d = HOLD;
      HOLD: ;
    endcase
    // A clear arriving during DETECT is dropped so the pulse always completes.
    if (clear && state_q != DETECT) begin
      state_d        = IDLE;
      hit_cnt_d      = 10'd0;
      miss_cnt_d     = 3'd0;
      detect_index_d = 16'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {sample_cnt_q, v1_q, abs_i_q, abs_q_q, pwr1_q, idx1_q, v2_q, lhs_q, rhs_q, pok_q, idx2_q} <= '0;
      {v3_q, hit3_q, idx3_q, hit_cnt_q, miss_cnt_q, detect_index_q} <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      {sample_cnt_q, v1_q, abs_i_q, abs_q_q, pwr1_q, idx1_q, v2_q, lhs_q, rhs_q, pok_q, idx2_q} <= '0;
      {v3_q, hit3_q, idx3_q, hit_cnt_q, miss_cnt_q, detect_index_q} <= '0;
    end else begin
      sample_cnt_q   <= sample_cnt_q + 16'(avg_valid);
      v1_q           <= avg_valid;
      abs_i_q        <= abs_sat(avg_corr_i);
      abs_q_q        <= abs_sat(avg_corr_q);
      pwr1_q         <= avg_pwr;
      idx1_q         <= sample_cnt_q;
      v2_q           <= v1_q;
      lhs_q          <= {mag, 3'b0};
      rhs_q          <= {4'b0, pwr1_q} * (W+4)'(THRESH_NUM);
      pok_q          <= pwr1_q >= W'(PWR_MIN);
      idx2_q         <= idx1_q;
      v3_q           <= v2_q;
      hit3_q         <= (lhs_q > rhs_q) && pok_q;
      idx3_q         <= idx2_q;
      state_q        <= state_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      detect_index_q <= detect_index_d;
    end
  end
  assign stf_detect   = state_q == DETECT;
  assign stf_detected = state_q[1];
  assign detect_index = detect_index_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_stf_plateau_detect.sv
// tb_stf_plateau_detect: directed self-checking bench for stf_plateau_detect (DATA_WIDTH=16)
module tb_stf_plateau_detect;
  logic        clk, rst_n, enable, clear, avg_valid;
  logic [15:0] avg_corr_i, avg_corr_q, avg_pwr;
  logic        stf_detect, stf_detected;
  logic [15:0] detect_index;
  logic [1:0]  state_dbg;
  int          n_chk, n_fail, det_cnt;
  logic [15:0] det_idx;
  stf_plateau_detect #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .avg_valid(avg_valid),
    .avg_corr_i(avg_corr_i), .avg_corr_q(avg_corr_q), .avg_pwr(avg_pwr),
    .stf_detect(stf_detect), .stf_detected(stf_detected),
    .detect_index(detect_index), .state_dbg(state_dbg)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial det_cnt = 0;
  always @(negedge clk) if (stf_detect) begin
    det_cnt = det_cnt + 1;
    det_idx = detect_index;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic smp(input logic [15:0] i, input logic [15:0] q, input logic [15:0] p);
    avg_valid = 1'b1; avg_corr_i = i; avg_corr_q = q; avg_pwr = p;
    @(posedge clk); #1;
    avg_valid = 1'b0;
  endtask
  task automatic burst(input int n, input logic [15:0] i, input logic [15:0] q, input logic [15:0] p);
    for (int k = 0; k < n; k++) smp(i, q, p);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask
  task automatic rearm();
    enable = 1'b0; idle(1); enable = 1'b1;
  endtask
  initial begin
    n_chk = 0; n_fail = 0; det_idx = '0;
    rst_n = 1'b1; enable = 1'b1; clear = 1'b0; avg_valid = 1'b0;
    avg_corr_i = '0; avg_corr_q = '0; avg_pwr = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_detect", 32'(stf_detect), 0);
    chk("rst_detected", 32'(stf_detected), 0);
    chk("rst_index", 32'(detect_index), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    // clean plateau: samples 0..31 hit, pulse three cycles after sample 31
    burst(32, 16'd1000, 16'd0, 16'd1000);
    idle(1); chk("clean_lat1", 32'(stf_detect), 0);
    idle(1); chk("clean_lat2", 32'(stf_detect), 0);
    idle(1);
    chk("clean_pulse", 32'(stf_detect), 1);
    chk("clean_level", 32'(stf_detected), 1);
    chk("clean_index", 32'(detect_index), 31);
    chk("clean_state_det", 32'(state_dbg), 2);
    idle(1);
    chk("clean_pulse_end", 32'(stf_detect), 0);
    chk("clean_state_hold", 32'(state_dbg), 3);
    burst(8, 16'd1000, 16'd0, 16'd1000); idle(4);
    chk("clean_one_pulse", 32'(det_cnt), 1);
    chk("clean_held_level", 32'(stf_detected), 1);
    chk("clean_held_index", 32'(detect_index), 31);
    rearm();
    chk("en_low_state", 32'(state_dbg), 0);
    chk("en_low_level", 32'(stf_detected), 0);
    chk("en_low_index", 32'(detect_index), 0);
    // tolerated dropout, Q-path hits
    burst(20, 16'd0, 16'hFC18, 16'd1000);
    burst(2, 16'd500, 16'd0, 16'd1000);
    burst(12, 16'd0, 16'hFC18, 16'd1000); idle(4);
    chk("tol_count", 32'(det_cnt), 2);
    chk("tol_index", 32'(detect_index), 33);
    chk("tol_state", 32'(state_dbg), 3);
    rearm();
    // excess dropout: back to IDLE, then 31 hits leaves RUN one short of a plateau
    burst(20, 16'd1000, 16'd0, 16'd1000);
    burst(3, 16'd500, 16'd0, 16'd1000);
    burst(31, 16'd1000, 16'd0, 16'd1000); idle(4);
    chk("exc_count", 32'(det_cnt), 2);
    chk("exc_state", 32'(state_dbg), 1);
    smp(16'd1000, 16'd0, 16'd1000); idle(4);
    chk("exc_next_count", 32'(det_cnt), 3);
    chk("exc_next_index", 32'(detect_index), 54);
    rearm();
    // power gate and threshold boundary
    burst(64, 16'd40, 16'd0, 16'd40); idle(4);
    chk("pwr_gate_state", 32'(state_dbg), 0);
    burst(64, 16'd750, 16'd0, 16'd1000); idle(4);
    chk("equal_state", 32'(state_dbg), 0);
    chk("gate_equal_count", 32'(det_cnt), 3);
    rearm();
    burst(32, 16'd751, 16'd0, 16'd1000); idle(4);
    chk("above_eq_count", 32'(det_cnt), 4);
    chk("above_eq_index", 32'(detect_index), 31);
    rearm();
    burst(32, 16'd64, 16'd0, 16'd64); idle(4);
    chk("pwr_min_count", 32'(det_cnt), 5);
    chk("pwr_min_index", 32'(detect_index), 31);
    rearm();
    // saturation: lhs 360424 vs rhs 360432 must miss; rhs 48000 must hit
    burst(32, 16'h8000, 16'h8000, 16'd60072); idle(4);
    chk("sat_tight_state", 32'(state_dbg), 0);
    burst(32, 16'h8000, 16'h8000, 16'd8000); idle(4);
    chk("sat_count", 32'(det_cnt), 6);
    chk("sat_index", 32'(detect_index), 63);
    rearm();
    // control: enable low mid-RUN
    burst(10, 16'd1000, 16'd0, 16'd1000);
    chk("ctl_run", 32'(state_dbg), 1);
    rearm();
    chk("ctl_en_state", 32'(state_dbg), 0);
    burst(31, 16'd1000, 16'd0, 16'd1000); idle(4);
    chk("ctl_31_count", 32'(det_cnt), 6);
    chk("ctl_31_state", 32'(state_dbg), 1);
    burst(5, 16'd1000, 16'd0, 16'd1000);
    chk("ctl_hold", 32'(state_dbg), 3);
    chk("ctl_det_index", 32'(det_idx), 31);
    clear = 1'b1;
    smp(16'd1000, 16'd0, 16'd1000);
    clear = 1'b0;
    chk("clr_state", 32'(state_dbg), 0);
    chk("clr_level", 32'(stf_detected), 0);
    chk("clr_index", 32'(detect_index), 0);
    smp(16'd1000, 16'd0, 16'd1000);
    chk("clr_rerun", 32'(state_dbg), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state_dbg), 0);
    chk("async_level", 32'(stf_detected), 0);
    chk("async_detect", 32'(stf_detect), 0);
    chk("async_index", 32'(detect_index), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(4);
    chk("post_rst_state", 32'(state_dbg), 0);
    chk("final_count", 32'(det_cnt), 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
